// File: rtl/regfile_pkg.sv
// Shared widths, FSM states and requester IDs for the
// register-file write arbiter.
package regfile_pkg;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int NREGS = 1 << AW;

  localparam logic [AW:0] CLR_LAST =
    (AW + 1)'(NREGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; prio names the requester
// that wins the next tie and flips after every grant.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt[prio_q] = 1'b1;
      (req == 2'b01): gnt[REQ_A]  = 1'b1;
      (req == 2'b10): gnt[REQ_B]  = 1'b1;
      default:        gnt         = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[REQ_A])
      prio_d = REQ_B;
    else if (gnt[REQ_B])
      prio_d = REQ_A;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prio_q <= REQ_A;
    else
      prio_q <= prio_d;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between requesters A and B.
// REGFILE_ARB_CLEAR_EN adds a post-reset zeroing sweep.
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          we,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          busy
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          run;

  logic          we_q;
  logic          we_d;
  logic [AW-1:0] wa3_q;
  logic [AW-1:0] wa3_d;
  logic [DW-1:0] wd3_q;
  logic [DW-1:0] wd3_d;

`ifdef REGFILE_ARB_CLEAR_EN
  state_e        state_q;
  state_e        state_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;

  assign run  = (state_q == RUN);
  assign busy = (state_q == CLEAR);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  assign req = run ? {b_valid, a_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign a_ready = gnt[REQ_A];
  assign b_ready = gnt[REQ_B];

  always_comb begin
    we_d  = |gnt;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    unique case (1'b1)
      gnt[REQ_A]: begin
        wa3_d = a_addr;
        wd3_d = a_data;
      end
      gnt[REQ_B]: begin
        wa3_d = b_addr;
        wd3_d = b_data;
      end
      default: begin
        wa3_d = wa3_q;
        wd3_d = wd3_q;
      end
    endcase
`ifdef REGFILE_ARB_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    // Sweep owns the port; arbiter sees no requests here.
    if (state_q == CLEAR) begin
      we_d  = 1'b1;
      wa3_d = cnt_q[AW-1:0];
      wd3_d = '0;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CLR_LAST)
        state_d = RUN;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q  <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      we_q  <= we_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
    end
  end

`ifdef REGFILE_ARB_CLEAR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign we  = we_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a regfile model;
// sweep checks compile in when REGFILE_ARB_CLEAR_EN is set.
module tb_regfile_wr_arbiter;

`ifdef REGFILE_ARB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0;
  logic [3:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [3:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready;
  logic       we;
  logic [3:0] wa3;
  logic [7:0] wd3;
  logic       busy;

  int vectors = 0;
  int errs = 0;

  logic [7:0] rf [16];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (we === 1'b1) rf[wa3] <= wd3;

  regfile_wr_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .b_ready (b_ready),
    .we      (we),
    .wa3     (wa3),
    .wd3     (wd3),
    .busy    (busy)
  );

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit done;
    align();
    reset = 1'b1;
    align();
    reset = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      errs++;
      $display("FAIL sweep_end busy=%b req=0", busy);
    end
  endtask

  task automatic test_reset();
    align();
    reset = 1'b1;
    #1;
    vectors++;
    if ({we, wa3, wd3} !== 13'h0) begin
      errs++;
      $display("FAIL reset_out got=%b/%h/%h req=0/0/00",
               we, wa3, wd3);
    end
    vectors++;
    if (busy !== CLR) begin
      errs++;
      $display("FAIL reset_busy got=%b req=%b", busy, CLR);
    end
    vectors++;
    if ({a_ready, b_ready} !== 2'b00) begin
      errs++;
      $display("FAIL reset_rdy got=%b req=00",
               {a_ready, b_ready});
    end
  endtask

`ifdef REGFILE_ARB_CLEAR_EN
  task automatic test_clear_hold();
    align();
    reset = 1'b1;
    align();
    reset   = 1'b0;
    a_valid = 1'b1; a_addr = 4'd4; a_data = 8'h44;
    b_valid = 1'b1; b_addr = 4'd5; b_data = 8'h55;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, a_ready, b_ready} !== 3'b100) begin
        errs++;
        $display("FAIL clr_busy%0d got=%b req=100", i,
                 {busy, a_ready, b_ready});
      end
      @(posedge clk); #1;
      vectors++;
      if ({we, wa3, wd3} !== {1'b1, 4'(i), 8'h00}) begin
        errs++;
        $display("FAIL clr_wr%0d got=%b/%h/%h req=1/%h/00",
                 i, we, wa3, wd3, 4'(i));
      end
    end
    @(negedge clk);
    vectors++;
    if ({busy, a_ready, b_ready} !== 3'b010) begin
      errs++;
      $display("FAIL clr_first got=%b req=010",
               {busy, a_ready, b_ready});
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    for (int r = 0; r < 16; r++) begin
      vectors++;
      if (rf[r] !== 8'h00) begin
        errs++;
        $display("FAIL clr_rf%0d got=%h req=00", r, rf[r]);
      end
    end
    vectors++;
    if ({we, wa3, wd3} !== {1'b1, 4'd4, 8'h44}) begin
      errs++;
      $display("FAIL clr_a got=%b/%h/%h req=1/4/44",
               we, wa3, wd3);
    end
    @(negedge clk);
    vectors++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errs++;
      $display("FAIL clr_b_rdy got=%b req=01",
               {a_ready, b_ready});
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
    vectors++;
    if ({we, wa3, wd3} !== {1'b1, 4'd5, 8'h55}) begin
      errs++;
      $display("FAIL clr_b got=%b/%h/%h req=1/5/55",
               we, wa3, wd3);
    end
  endtask

  task automatic test_sweep_reset();
    bit seen;
    align();
    reset = 1'b1;
    align();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (we === 1'b1 && wa3 === 4'd9) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      errs++;
      $display("FAIL swr_reach got=%h req=9", wa3);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({we, wa3, wd3, busy} !== 14'h1) begin
      errs++;
      $display("FAIL swr_out got=%b/%h/%h/%b req=0/0/00/1",
               we, wa3, wd3, busy);
    end
    align();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
        errs++;
        $display("FAIL swr_busy%0d got=%b req=1", i, busy);
      end
      @(posedge clk); #1;
      vectors++;
      if ({we, wa3, wd3} !== {1'b1, 4'(i), 8'h00}) begin
        errs++;
        $display("FAIL swr_wr%0d got=%b/%h/%h req=1/%h/00",
                 i, we, wa3, wd3, 4'(i));
      end
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL swr_done got=%b req=0", busy);
    end
  endtask
`endif

  task automatic test_single_a();
    align();
    a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h5A;
    @(negedge clk);
    vectors++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errs++;
      $display("FAIL sa_rdy got=%b req=10",
               {a_ready, b_ready});
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    vectors++;
    if ({we, wa3, wd3} !== {1'b1, 4'd3, 8'h5A}) begin
      errs++;
      $display("FAIL sa_wr got=%b/%h/%h req=1/3/5a",
               we, wa3, wd3);
    end
    @(posedge clk); #1;
    vectors++;
    if ({we, wa3} !== {1'b0, 4'd3}) begin
      errs++;
      $display("FAIL sa_idle got=%b/%h req=0/3", we, wa3);
    end
    vectors++;
    if (rf[3] !== 8'h5A) begin
      errs++;
      $display("FAIL sa_rd got=%h req=5a", rf[3]);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] ea;
    logic [7:0] ed;
    align();
    a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({a_ready, b_ready} !==
          ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errs++;
        $display("FAIL alt_rdy%0d got=%b", k,
                 {a_ready, b_ready});
      end
      ea = (k % 2 == 0) ? 4'd1 : 4'd2;
      ed = ((k % 2 == 0) ? 8'h11 : 8'h22) + 8'(k / 2);
      @(posedge clk); #1;
      vectors++;
      if ({we, wa3, wd3} !== {1'b1, ea, ed}) begin
        errs++;
        $display("FAIL alt_wr%0d got=%b/%h/%h req=1/%h/%h",
                 k, we, wa3, wd3, ea, ed);
      end
      if (k % 2 == 0) a_data = a_data + 8'h1;
      else            b_data = b_data + 8'h1;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_same_addr();
    align();
    a_valid = 1'b1; a_addr = 4'd7; a_data = 8'hAA;
    b_valid = 1'b1; b_addr = 4'd7; b_data = 8'hBB;
    @(negedge clk);
    vectors++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errs++;
      $display("FAIL r7_a got=%b req=10", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errs++;
      $display("FAIL r7_b got=%b req=01", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
    vectors++;
    if (rf[7] !== 8'hAA) begin
      errs++;
      $display("FAIL r7_mid got=%h req=aa", rf[7]);
    end
    @(posedge clk); #1;
    vectors++;
    if (rf[7] !== 8'hBB) begin
      errs++;
      $display("FAIL r7_end got=%h req=bb", rf[7]);
    end
  endtask

  task automatic test_b_only();
    align();
    b_valid = 1'b1; b_addr = 4'd9; b_data = 8'h99;
    @(negedge clk);
    vectors++;
    if ({a_ready, b_ready} !== 2'b01) begin
      errs++;
      $display("FAIL bo_rdy got=%b req=01", {a_ready, b_ready});
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
    vectors++;
    if ({we, wa3, wd3} !== {1'b1, 4'd9, 8'h99}) begin
      errs++;
      $display("FAIL bo_wr got=%b/%h/%h req=1/9/99",
               we, wa3, wd3);
    end
  endtask

  task automatic test_idle();
    align();
    @(negedge clk);
    vectors++;
    if ({a_ready, b_ready} !== 2'b00) begin
      errs++;
      $display("FAIL idle_rdy got=%b req=00",
               {a_ready, b_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if ({we, wa3, wd3} !== {1'b0, 4'd9, 8'h99}) begin
      errs++;
      $display("FAIL idle_hold got=%b/%h/%h req=0/9/99",
               we, wa3, wd3);
    end
  endtask

  task automatic test_reset_mid();
    align();
    a_valid = 1'b1; a_addr = 4'hE; a_data = 8'hEE;
    @(posedge clk); #1;
    a_valid = 1'b0;
    vectors++;
    if (we !== 1'b1) begin
      errs++;
      $display("FAIL rm_pre got=%b req=1", we);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({we, wa3, wd3, busy} !== {13'h0, CLR}) begin
      errs++;
      $display("FAIL rm_out got=%b/%h/%h/%b req=0/0/00/%b",
               we, wa3, wd3, busy, CLR);
    end
    @(posedge clk); #1;
    vectors++;
    if (rf[14] === 8'hEE) begin
      errs++;
      $display("FAIL rm_drop got=%h req=not ee", rf[14]);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    do_reset();
`ifdef REGFILE_ARB_CLEAR_EN
    test_clear_hold();
    test_sweep_reset();
    do_reset();
`endif
    test_single_a();
    do_reset();
    test_alternate();
    test_same_addr();
    test_b_only();
    test_idle();
    test_reset_mid();
    do_reset();
    test_single_a();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
